// File: rtl/ram_master_pkg.sv
// Shared definitions for the Ram initiator: FSM state encoding and default bus widths.
package ram_master_pkg;

    localparam int unsigned DEF_COL_W  = 5;
    localparam int unsigned DEF_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_master_if.sv
// Client request/response handshake plus the single-port Ram bus, seen from both sides.
interface ram_master_if
    import ram_master_pkg::*;
#(
    parameter int unsigned bitOfColumn = DEF_COL_W,
    parameter int unsigned bitPerWord  = DEF_WORD_W
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [bitOfColumn-1:0] ReqAddr;
    logic [bitOfColumn-1:0] ReqLen;
    logic [bitPerWord-1:0]  ReqData;
    logic                   RspValid;
    logic                   RspReady;
    logic [bitPerWord-1:0]  RspData;
    logic                   RspLast;
    logic                   Done;
    logic [bitOfColumn-1:0] Addr;
    logic [bitPerWord-1:0]  DataIn;
    logic                   RWS;
    logic                   CS;
    logic [bitPerWord-1:0]  DataOut;

    modport master (
        input  ReqValid, ReqWrite, ReqAddr, ReqLen, ReqData, RspReady, DataOut,
        output ReqReady, RspValid, RspData, RspLast, Done, Addr, DataIn, RWS, CS
    );

    modport slave (
        output ReqValid, ReqWrite, ReqAddr, ReqLen, ReqData, RspReady, DataOut,
        input  ReqReady, RspValid, RspData, RspLast, Done, Addr, DataIn, RWS, CS
    );

endinterface

// File: rtl/ram_master.sv
// Ram initiator: runs each word access as SETUP/STROBE/HOLD so Addr, DataIn and RWS
// are stable for the whole time CS is high; bursts walk the address modulo 2**bitOfColumn.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int unsigned bitOfColumn = DEF_COL_W,
    parameter int unsigned bitPerWord  = DEF_WORD_W
) (
    input  logic           Clk,
    input  logic           Rst_n,
    ram_master_if.master   bus
);

    localparam logic [bitOfColumn-1:0] ONE = bitOfColumn'(1);

    state_e                 state_q, state_d;
    logic [bitOfColumn-1:0] addr_q, addr_d;
    logic [bitOfColumn-1:0] cnt_q, cnt_d;
    logic [bitPerWord-1:0]  din_q, din_d;
    logic                   rws_q, rws_d;
    logic                   cs_q, cs_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [bitPerWord-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_last_q, rsp_last_d;
    logic                   done_q, done_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            din_q       <= '0;
            rws_q       <= 1'b0;
            cs_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            rws_q       <= rws_d;
            cs_q        <= cs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        din_d       = din_q;
        rws_d       = rws_q;
        cs_d        = cs_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    addr_d  = bus.ReqAddr;
                    din_d   = bus.ReqData;
                    rws_d   = bus.ReqWrite;
                    cnt_d   = bus.ReqLen;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_d    = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                cs_d = 1'b0;
                if (!rws_q) begin
                    rsp_data_d  = bus.DataOut;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (cnt_q == '0);
                end
                state_d = HOLD;
            end
            HOLD: begin
                // A read parks here until the client takes the word; writes never stall.
                if (rws_q || !rsp_valid_q || bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ONE;
                        cnt_d   = cnt_q - ONE;
                        state_d = SETUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ReqReady = (state_q == IDLE);
    assign bus.RspValid = rsp_valid_q;
    assign bus.RspData  = rsp_data_q;
    assign bus.RspLast  = rsp_last_q;
    assign bus.Done     = done_q;
    assign bus.Addr     = addr_q;
    assign bus.DataIn   = din_q;
    assign bus.RWS      = rws_q;
    assign bus.CS       = cs_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master driving a behavioural Ram; read responses are checked by a scoreboard monitor.
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;
    logic mem_init;

    ram_master_if #(.bitOfColumn(AW), .bitPerWord(DW)) bus ();

    ram_master #(.bitOfColumn(AW), .bitPerWord(DW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] mem [2**AW];

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i);
        end else if (bus.CS && bus.RWS) begin
            mem[bus.Addr] <= bus.DataIn;
        end
    end

    assign bus.DataOut = mem[bus.Addr];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } rsp_t;

    rsp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n && bus.RspValid && bus.RspReady) begin
            rsp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data %0h expected no response", bus.RspData);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(bus.RspData), 32'(e.d));
                chk("rsp_last", 32'(bus.RspLast), 32'(e.last));
            end
        end
    end

    logic          prev_cs;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;
    logic          prev_rws;

    initial prev_cs = 1'b0;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_cs = 1'b0;
        end else begin
            if (bus.CS) chk("cs_one_cycle", 32'(prev_cs), 32'd0);
            if (bus.CS || prev_cs)
                chk("bus_stable", 32'({bus.Addr, bus.DataIn, bus.RWS}),
                    32'({prev_addr, prev_din, prev_rws}));
            prev_cs   = bus.CS;
            prev_addr = bus.Addr;
            prev_din  = bus.DataIn;
            prev_rws  = bus.RWS;
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                         input logic [DW-1:0] d);
        int t = 0;
        @(posedge Clk); #1;
        while (!bus.ReqReady && t < 100) begin
            @(posedge Clk); #1;
            t++;
        end
        chk("req_ready", 32'(bus.ReqReady), 32'd1);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = w;
        bus.ReqAddr  = a;
        bus.ReqLen   = l;
        bus.ReqData  = d;
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int stb);
        cyc = 0;
        stb = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (bus.CS) stb++;
        end while (!bus.Done && cyc < 500);
        chk("done_seen", 32'(bus.Done), 32'd1);
        chk("ready_at_done", 32'(bus.ReqReady), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, stb, k;

        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqLen   = '0;
        bus.ReqData  = '0;
        bus.RspReady = 1'b1;
        mem_init     = 1'b1;

        // Asynchronous reset: checked before the first clock edge.
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_cs",       32'(bus.CS),       32'd0);
        chk("rst_rws",      32'(bus.RWS),      32'd0);
        chk("rst_addr",     32'(bus.Addr),     32'd0);
        chk("rst_datain",   32'(bus.DataIn),   32'd0);
        chk("rst_rspvalid", 32'(bus.RspValid), 32'd0);
        chk("rst_rspdata",  32'(bus.RspData),  32'd0);
        chk("rst_done",     32'(bus.Done),     32'd0);
        chk("rst_reqready", 32'(bus.ReqReady), 32'd1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        mem_init = 1'b0;
        Rst_n    = 1'b1;

        // Single write then read-back.
        issue(1'b1, 5'd5, 5'd0, 8'hA5);
        wait_done(cyc, stb);
        chk("wr1_latency", 32'(cyc), 32'd4);
        chk("wr1_strobes", 32'(stb), 32'd1);
        chk("wr1_mem5",    32'(mem[5]), 32'hA5);

        exp_q.push_back('{d: 8'hA5, last: 1'b1});
        issue(1'b0, 5'd5, 5'd0, 8'h00);
        wait_done(cyc, stb);
        chk("rd1_latency", 32'(cyc), 32'd4);
        chk("rd1_strobes", 32'(stb), 32'd1);

        // Fill across the top of the address space.
        issue(1'b1, 5'd30, 5'd3, 8'h3C);
        wait_done(cyc, stb);
        chk("fill_latency", 32'(cyc), 32'd13);
        chk("fill_strobes", 32'(stb), 32'd4);
        chk("fill_mem30",   32'(mem[30]), 32'h3C);
        chk("fill_mem31",   32'(mem[31]), 32'h3C);
        chk("fill_mem0",    32'(mem[0]),  32'h3C);
        chk("fill_mem1",    32'(mem[1]),  32'h3C);
        chk("fill_mem29",   32'(mem[29]), 32'h1D);

        exp_q.push_back('{d: 8'h3C, last: 1'b0});
        exp_q.push_back('{d: 8'h3C, last: 1'b0});
        exp_q.push_back('{d: 8'h3C, last: 1'b0});
        exp_q.push_back('{d: 8'h3C, last: 1'b1});
        issue(1'b0, 5'd30, 5'd3, 8'h00);
        wait_done(cyc, stb);
        chk("rdb_latency", 32'(cyc), 32'd13);
        chk("rdb_strobes", 32'(stb), 32'd4);

        // Backpressure on a two-word read.
        bus.RspReady = 1'b0;
        exp_q.push_back('{d: 8'h3C, last: 1'b0});
        exp_q.push_back('{d: 8'h3C, last: 1'b1});
        issue(1'b0, 5'd31, 5'd1, 8'h00);
        k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!bus.RspValid && k < 50);
        chk("bp_valid_seen", 32'(bus.RspValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            chk("bp_valid", 32'(bus.RspValid), 32'd1);
            chk("bp_data",  32'(bus.RspData),  32'h3C);
            chk("bp_last",  32'(bus.RspLast),  32'd0);
            chk("bp_cs",    32'(bus.CS),       32'd0);
            chk("bp_done",  32'(bus.Done),     32'd0);
        end
        @(posedge Clk); #1;
        bus.RspReady = 1'b1;
        wait_done(cyc, stb);
        chk("bp_latency", 32'(cyc), 32'd5);
        chk("bp_strobes", 32'(stb), 32'd1);

        // Reset in the middle of a full fill, while word 10 is strobed.
        issue(1'b1, 5'd0, 5'd31, 8'h77);
        k = 0;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (bus.CS) k++;
        end while (k < 11 && cyc < 200);
        chk("mr_reached_word10", 32'(k), 32'd11);
        #1 Rst_n = 1'b0;
        #1;
        chk("mr_cs_drop",   32'(bus.CS),       32'd0);
        chk("mr_reqready",  32'(bus.ReqReady), 32'd1);
        chk("mr_rspvalid",  32'(bus.RspValid), 32'd0);
        @(posedge Clk);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("mr_ready_after", 32'(bus.ReqReady), 32'd1);
        chk("mr_cs_after",    32'(bus.CS),       32'd0);
        for (int i = 0; i < 10; i++) chk("mr_fill_word", 32'(mem[i]), 32'h77);
        chk("mr_mem11", 32'(mem[11]), 32'h0B);
        chk("mr_mem29", 32'(mem[29]), 32'h1D);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
